// File: rtl/pact_cache_control_arbiter_pkg.sv
// Shared definitions for the cache control arbiter: controller states,
// the cache command width and the line-mask helper.
package pact_cache_control_arbiter_pkg;

    // Command width of the parallel cache control port
    localparam int BW_CACHE_COMMAND = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_e;

    // Byte-offset mask within one cache line; line_size must be a power of 2
    function automatic logic [63:0] line_mask(input int unsigned line_size);
        return 64'(line_size) - 64'd1;
    endfunction

endpackage

// File: rtl/pact_cache_control_arbiter_rr_picker.sv
// Round-robin picker: first valid requester at or after last_grant+1, with wrap.
// Purely combinational; no backpressure of its own.
module pact_rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         valid_list,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic                       any_valid,
    output logic [NUM_REQ-1:0]         grant_onehot,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    function automatic int wrap_idx(input int v);
        return (v >= NUM_REQ) ? v - NUM_REQ : v;
    endfunction

    always_comb begin
        any_valid    = 1'b0;
        grant_onehot = '0;
        grant_idx    = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!any_valid && valid_list[wrap_idx(int'(last_grant) + off)]) begin
                any_valid = 1'b1;
                grant_idx = IDX_W'(wrap_idx(int'(last_grant) + off));
                grant_onehot[wrap_idx(int'(last_grant) + off)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pact_cache_control_arbiter.sv
// Shares one cache control port among NUM_REQ requesters, round-robin, one op in flight.
// Latency: done 3 cycles after accept (1 for empty ranges); ISSUE holds valid until cache ready.
// WAIT holds until cache busy drops; PACT_CACHE_CTRL_TIMEOUT_EN adds a WAIT timeout.
module pact_cache_control_arbiter
    import pact_cache_control_arbiter_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int BW_ADDR         = 32,
    parameter int CACHE_LINE_SIZE = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                                clk,
    input  logic                                rstnn,
    input  logic [NUM_REQ-1:0]                  req_valid_list,
    output logic [NUM_REQ-1:0]                  req_ready_list,
    input  logic [NUM_REQ*BW_CACHE_COMMAND-1:0] req_command_list,
    input  logic [NUM_REQ*BW_ADDR-1:0]          req_base_list,
    input  logic [NUM_REQ*BW_ADDR-1:0]          req_last_list,
    output logic [NUM_REQ-1:0]                  req_done_list,
    output logic                                cache_control_valid,
    input  logic                                cache_control_ready,
    output logic [BW_CACHE_COMMAND-1:0]         cache_control_command,
    output logic [BW_ADDR-1:0]                  cache_control_base,
    output logic [BW_ADDR-1:0]                  cache_control_last,
    input  logic                                cache_control_busy,
    output logic                                busy,
    output logic                                timeout_error
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [BW_ADDR-1:0] LINE_MASK = BW_ADDR'(line_mask(CACHE_LINE_SIZE));

    ctrl_state_e                 state_q, state_d;
    logic [IDX_W-1:0]            grant_q, grant_d;
    logic [IDX_W-1:0]            last_grant_q, last_grant_d;
    logic [BW_CACHE_COMMAND-1:0] cmd_q, cmd_d;
    logic [BW_ADDR-1:0]          base_q, base_d;
    logic [BW_ADDR-1:0]          last_q, last_d;

    logic [BW_CACHE_COMMAND-1:0] cmd_arr  [NUM_REQ];
    logic [BW_ADDR-1:0]          base_arr [NUM_REQ];
    logic [BW_ADDR-1:0]          last_arr [NUM_REQ];

    logic                        pick_any;
    logic [NUM_REQ-1:0]          pick_onehot;
    logic [IDX_W-1:0]            pick_idx;
    logic                        pick_empty;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign cmd_arr[i]  = req_command_list[i*BW_CACHE_COMMAND +: BW_CACHE_COMMAND];
        assign base_arr[i] = req_base_list[i*BW_ADDR +: BW_ADDR];
        assign last_arr[i] = req_last_list[i*BW_ADDR +: BW_ADDR];
    end

    pact_rr_picker #(
        .NUM_REQ      (NUM_REQ)
    ) u_picker (
        .valid_list   (req_valid_list),
        .last_grant   (last_grant_q),
        .any_valid    (pick_any),
        .grant_onehot (pick_onehot),
        .grant_idx    (pick_idx)
    );

    // Emptiness is judged on the raw range, before line alignment widens it
    assign pick_empty = base_arr[pick_idx] > last_arr[pick_idx];

`ifdef PACT_CACHE_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`else
    logic [31:0]      timeout_cycles_unused;
    assign timeout_cycles_unused = TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_grant_d   = last_grant_q;
        cmd_d          = cmd_q;
        base_d         = base_q;
        last_d         = last_q;
        req_ready_list = '0;
        req_done_list  = '0;
`ifdef PACT_CACHE_CTRL_TIMEOUT_EN
        cnt_d          = '0;
        timeout_d      = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    req_ready_list = pick_onehot;
                    grant_d        = pick_idx;
                    cmd_d          = cmd_arr[pick_idx];
                    base_d         = base_arr[pick_idx] & ~LINE_MASK;
                    last_d         = last_arr[pick_idx] | LINE_MASK;
                    state_d        = pick_empty ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cache_control_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
`ifdef PACT_CACHE_CTRL_TIMEOUT_EN
                // Count hits TIMEOUT_CYCLES on the transition out of the last WAIT cycle
                if (!cache_control_busy) begin
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`else
                if (!cache_control_busy) begin
                    state_d = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                req_done_list[grant_q] = 1'b1;
                last_grant_d           = grant_q;
                state_d                = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Keep the accept pulse quiet while reset is held
        if (!rstnn) begin
            req_ready_list = '0;
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            cmd_q        <= '0;
            base_q       <= '0;
            last_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cmd_q        <= cmd_d;
            base_q       <= base_d;
            last_q       <= last_d;
        end
    end

`ifdef PACT_CACHE_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout_error = timeout_q;
`else
    assign timeout_error = 1'b0;
`endif

    assign cache_control_valid   = (state_q == ST_ISSUE);
    assign cache_control_command = cmd_q;
    assign cache_control_base    = base_q;
    assign cache_control_last    = last_q;
    assign busy                  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pact_cache_control_arbiter.sv
// Directed bench for pact_cache_control_arbiter: reset, single op, alignment,
// contention rotation, empty range, reset mid-WAIT and (with the macro) timeout.
module tb_pact_cache_control_arbiter;

    localparam int NUM_REQ = 4;
    localparam int BW_ADDR = 32;
    localparam int BW_CMD  = 2;

    logic                        clk = 1'b0;
    logic                        rstnn;
    logic [NUM_REQ-1:0]          req_valid_list;
    logic [NUM_REQ-1:0]          req_ready_list;
    logic [NUM_REQ*BW_CMD-1:0]   req_command_list;
    logic [NUM_REQ*BW_ADDR-1:0]  req_base_list;
    logic [NUM_REQ*BW_ADDR-1:0]  req_last_list;
    logic [NUM_REQ-1:0]          req_done_list;
    logic                        cache_control_valid;
    logic                        cache_control_ready;
    logic [BW_CMD-1:0]           cache_control_command;
    logic [BW_ADDR-1:0]          cache_control_base;
    logic [BW_ADDR-1:0]          cache_control_last;
    logic                        cache_control_busy;
    logic                        busy;
    logic                        timeout_error;

    int checks = 0;
    int errors = 0;

    pact_cache_control_arbiter #(
        .NUM_REQ               (NUM_REQ),
        .BW_ADDR               (BW_ADDR),
        .CACHE_LINE_SIZE       (16),
        .TIMEOUT_CYCLES        (16)
    ) dut (
        .clk                   (clk),
        .rstnn                 (rstnn),
        .req_valid_list        (req_valid_list),
        .req_ready_list        (req_ready_list),
        .req_command_list      (req_command_list),
        .req_base_list         (req_base_list),
        .req_last_list         (req_last_list),
        .req_done_list         (req_done_list),
        .cache_control_valid   (cache_control_valid),
        .cache_control_ready   (cache_control_ready),
        .cache_control_command (cache_control_command),
        .cache_control_base    (cache_control_base),
        .cache_control_last    (cache_control_last),
        .cache_control_busy    (cache_control_busy),
        .busy                  (busy),
        .timeout_error         (timeout_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] cmd,
                           input logic [31:0] b, input logic [31:0] l);
        req_valid_list[i]              = v;
        req_command_list[i*BW_CMD +: BW_CMD]   = cmd;
        req_base_list[i*BW_ADDR +: BW_ADDR]    = b;
        req_last_list[i*BW_ADDR +: BW_ADDR]    = l;
    endtask

    // Requester i owns range 0x100*(i+1)+4 .. 0x100*(i+1)+0x20
    task automatic set_std(input int i, input logic v);
        set_req(i, v, 2'(i), 32'(32'h100 * (i + 1) + 4), 32'(32'h100 * (i + 1) + 32'h20));
    endtask

    // Serve one standard request with immediate ready and busy low
    task automatic serve(input string tag, input int idx);
        int n = 0;
        logic [3:0] exp_g;
        exp_g = 4'b0001 << idx;
        while (req_ready_list == 4'b0 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, req_ready_list, exp_g);
        tick();
        chk({tag, "_valid"}, cache_control_valid, 1);
        chk({tag, "_base"}, cache_control_base, 32'(32'h100 * (idx + 1)));
        cache_control_ready = 1'b1;
        tick();
        cache_control_ready = 1'b0;
        tick();
        chk({tag, "_done"}, req_done_list, exp_g);
        chk({tag, "_nogrant"}, req_ready_list, 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1);
    end

    initial begin
        rstnn               = 1'b0;
        req_valid_list      = '0;
        req_command_list    = '0;
        req_base_list       = '0;
        req_last_list       = '0;
        cache_control_ready = 1'b0;
        cache_control_busy  = 1'b0;
        #1;
        chk("rst_ready", req_ready_list, 0);
        chk("rst_done", req_done_list, 0);
        chk("rst_valid", cache_control_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_base", cache_control_base, 0);
        chk("rst_timeout", timeout_error, 0);
        tick();
        tick();
        rstnn = 1'b1;
        tick();

        // Contention: 0,1,2 held -> 0,1,2,0; then 0 and 3 -> 3,0
        for (int i = 0; i < 3; i++) set_std(i, 1'b1);
        #1;
        serve("cont0", 0);
        serve("cont1", 1);
        serve("cont2", 2);
        serve("cont0b", 0);
        set_std(1, 1'b0);
        set_std(2, 1'b0);
        set_std(3, 1'b1);
        #1;
        serve("cont3", 3);
        serve("cont0c", 0);
        req_valid_list = '0;
        tick();

        // Single request: ready after 2 ISSUE cycles, busy high 3 cycles
        set_req(0, 1'b1, 2'd1, 32'h1000, 32'h10FF);
        #1;
        chk("single_ready", req_ready_list, 4'b0001);
        tick();
        req_valid_list = '0;
        chk("single_valid1", cache_control_valid, 1);
        chk("single_base", cache_control_base, 32'h1000);
        chk("single_last", cache_control_last, 32'h10FF);
        chk("single_cmd", cache_control_command, 2'd1);
        tick();
        chk("single_valid2", cache_control_valid, 1);
        chk("single_base2", cache_control_base, 32'h1000);
        cache_control_ready = 1'b1;
        tick();
        cache_control_ready = 1'b0;
        cache_control_busy  = 1'b1;
        chk("single_valid_drop", cache_control_valid, 0);
        chk("single_busy", busy, 1);
        tick();
        chk("single_w1", req_done_list, 0);
        tick();
        chk("single_w2", req_done_list, 0);
        tick();
        chk("single_w3", req_done_list, 0);
        cache_control_busy = 1'b0;
        tick();
        chk("single_done", req_done_list, 4'b0001);
        tick();
        chk("single_done_once", req_done_list, 0);
        chk("single_idle", busy, 0);

        // Alignment to 16-byte lines, minimum latency
        set_req(1, 1'b1, 2'd2, 32'h1004, 32'h1008);
        #1;
        chk("align_ready", req_ready_list, 4'b0010);
        tick();
        req_valid_list      = '0;
        cache_control_ready = 1'b1;
        chk("align_base", cache_control_base, 32'h1000);
        chk("align_last", cache_control_last, 32'h100F);
        tick();
        cache_control_ready = 1'b0;
        chk("align_wait", req_done_list, 0);
        tick();
        chk("align_done", req_done_list, 4'b0010);
        tick();

        // Empty range: no cache command, done one cycle after accept
        set_req(2, 1'b1, 2'd0, 32'h2000, 32'h1FFF);
        #1;
        chk("empty_ready", req_ready_list, 4'b0100);
        tick();
        req_valid_list = '0;
        chk("empty_valid", cache_control_valid, 0);
        chk("empty_done", req_done_list, 4'b0100);
        tick();
        chk("empty_idle", busy, 0);
        chk("empty_valid2", cache_control_valid, 0);

        // Reset while in WAIT
        set_req(1, 1'b1, 2'd3, 32'h204, 32'h220);
        #1;
        chk("rw_ready", req_ready_list, 4'b0010);
        tick();
        req_valid_list      = '0;
        cache_control_ready = 1'b1;
        tick();
        cache_control_ready = 1'b0;
        cache_control_busy  = 1'b1;
        tick();
        chk("rw_busy", busy, 1);
        rstnn = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_std(i, 1'b1);
        #1;
        chk("rw_rst_ready", req_ready_list, 0);
        chk("rw_rst_valid", cache_control_valid, 0);
        chk("rw_rst_busy", busy, 0);
        chk("rw_rst_done", req_done_list, 0);
        chk("rw_rst_last", cache_control_last, 0);
        tick();
        rstnn              = 1'b1;
        cache_control_busy = 1'b0;
        #1;
        chk("rw_no_done", req_done_list, 0);
        serve("rw_next", 0);
        req_valid_list = '0;
        tick();

`ifdef PACT_CACHE_CTRL_TIMEOUT_EN
        set_req(3, 1'b1, 2'd1, 32'h3000, 32'h30FF);
        #1;
        chk("to_ready", req_ready_list, 4'b1000);
        tick();
        req_valid_list      = '0;
        cache_control_ready = 1'b1;
        cache_control_busy  = 1'b1;
        tick();
        cache_control_ready = 1'b0;
        for (int j = 1; j <= 15; j++) begin
            tick();
            if (j == 1 || j == 15) chk("to_pending", timeout_error, 0);
        end
        tick();
        chk("to_set", timeout_error, 1);
        chk("to_done", req_done_list, 4'b1000);
        tick();
        chk("to_sticky", timeout_error, 1);
        chk("to_done_once", req_done_list, 0);
        cache_control_busy = 1'b0;
        set_std(0, 1'b1);
        #1;
        serve("to_next", 0);
        chk("to_sticky2", timeout_error, 1);
        req_valid_list = '0;
`else
        chk("timeout_off", timeout_error, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
